// File: rtl/usb_spi_responder_pkg.sv
// usb_spi_resp_pkg: shared types and constants for the MAX3421E-style SPI
// responder.
//   state_e      : transaction FSM state {IDLE, CMD, DATA}
//   CMD_*        : bit positions of the address and direction fields in the
//                  command byte
//   REG_HIRQ/HIEN: interrupt request / interrupt enable register addresses
//   irq_asserted : interrupt condition (any enabled request bit set)
package usb_spi_resp_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    localparam int CMD_ADDR_MSB = 7;
    localparam int CMD_ADDR_LSB = 3;
    localparam int CMD_DIR_BIT  = 1;

    localparam logic [ADDR_W-1:0] REG_HIRQ = 5'd25;
    localparam logic [ADDR_W-1:0] REG_HIEN = 5'd26;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_e;

    // Interrupt is pending when any requested bit is also enabled
    function automatic logic irq_asserted(input logic [DATA_W-1:0] status,
                                          input logic [DATA_W-1:0] ien);
        return |(status & ien);
    endfunction

endpackage

// File: rtl/usb_spi_responder_if.sv
// usb_spi_responder_if: fabric-side register access port of the responder.
//   host_addr  : register address (5 bits)
//   host_we    : write strobe
//   host_wdata : write data
//   host_rdata : registered read data, one cycle after host_addr
// Modports: master = fabric logic driving the port, slave = the responder.
interface usb_spi_responder_if;
    import usb_spi_resp_pkg::*;

    logic [ADDR_W-1:0] host_addr;
    logic              host_we;
    logic [DATA_W-1:0] host_wdata;
    logic [DATA_W-1:0] host_rdata;

    modport master (
        output host_addr,
        output host_we,
        output host_wdata,
        input  host_rdata
    );

    modport slave (
        input  host_addr,
        input  host_we,
        input  host_wdata,
        output host_rdata
    );
endinterface

// File: rtl/usb_spi_responder_spi_pin_sync.sv
// spi_pin_sync: brings the asynchronous SPI pins into the clk domain.
//   clk, rst_n   : system clock, synchronous active-low reset
//   ss_n_i, sclk_i, mosi_i : raw SPI pins
//   ss_n_o, mosi_o         : 2-flop synchronized levels
//   sclk_rise_o/sclk_fall_o: one-cycle pulses on synchronized SCLK edges
//   ss_fall_o/ss_rise_o    : one-cycle pulses on synchronized SS_n edges
// The SS_n chain resets to 0 (selected) so that a transaction interrupted by
// reset produces no falling edge afterwards; the master must deselect and
// reselect before the responder engages again.
module spi_pin_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic ss_n_i,
    input  logic sclk_i,
    input  logic mosi_i,
    output logic ss_n_o,
    output logic mosi_o,
    output logic sclk_rise_o,
    output logic sclk_fall_o,
    output logic ss_fall_o,
    output logic ss_rise_o
);

    // [0] first stage, [1] synchronized level, [2] previous synchronized level
    logic [2:0] ss_q, ss_d;
    logic [2:0] sclk_q, sclk_d;
    logic [1:0] mosi_q, mosi_d;

    // Shift each pin into its synchronizer chain
    always_comb begin
        ss_d   = {ss_q[1:0], ss_n_i};
        sclk_d = {sclk_q[1:0], sclk_i};
        mosi_d = {mosi_q[0], mosi_i};
    end

    // Synchronizer flops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ss_q   <= 3'b000;
            sclk_q <= 3'b000;
            mosi_q <= 2'b00;
        end else begin
            ss_q   <= ss_d;
            sclk_q <= sclk_d;
            mosi_q <= mosi_d;
        end
    end

    assign ss_n_o      = ss_q[1];
    assign mosi_o      = mosi_q[1];
    assign sclk_rise_o =  sclk_q[1] & ~sclk_q[2];
    assign sclk_fall_o = ~sclk_q[1] &  sclk_q[2];
    assign ss_fall_o   = ~ss_q[1] &  ss_q[2];
    assign ss_rise_o   =  ss_q[1] & ~ss_q[2];

endmodule

// File: rtl/usb_spi_responder.sv
// usb_spi_responder: SPI mode-0 responder emulating the MAX3421E command and
// register protocol, with a 32x8 register bank shared with fabric logic.
//   Clk, Reset_n            : system clock, synchronous active-low reset
//   spi_ss_n/sclk/mosi      : SPI pins from the SoC master (asynchronous)
//   spi_miso, spi_miso_oe   : responder data out and its output enable
//   irq_n                   : low while (HIRQ & HIEN) != 0
//   host                    : fabric register port (usb_spi_responder_if)
//   spi_wr_pulse/addr/data  : strobe plus address/data of each SPI write
// Build option: define USB_SPI_RESP_AUTOINC_EN to advance the register
// address after every data byte (wrapping 31->0); without it the address
// stays fixed for the whole transaction (FIFO-style repeated access).
module usb_spi_responder
    import usb_spi_resp_pkg::*;
#(
    parameter int NREGS      = 32,
    parameter int STATUS_REG = int'(REG_HIRQ),
    parameter int IEN_REG    = int'(REG_HIEN)
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                spi_ss_n,
    input  logic                spi_sclk,
    input  logic                spi_mosi,
    output logic                spi_miso,
    output logic                spi_miso_oe,
    output logic                irq_n,
    usb_spi_responder_if.slave  host,
    output logic                spi_wr_pulse,
    output logic [ADDR_W-1:0]   spi_wr_addr,
    output logic [DATA_W-1:0]   spi_wr_data
);

    logic ss_n_s, mosi_s, sclk_rise_s, sclk_fall_s, ss_fall_s, ss_rise_s;

    spi_pin_sync u_sync (
        .clk         (Clk),
        .rst_n       (Reset_n),
        .ss_n_i      (spi_ss_n),
        .sclk_i      (spi_sclk),
        .mosi_i      (spi_mosi),
        .ss_n_o      (ss_n_s),
        .mosi_o      (mosi_s),
        .sclk_rise_o (sclk_rise_s),
        .sclk_fall_o (sclk_fall_s),
        .ss_fall_o   (ss_fall_s),
        .ss_rise_o   (ss_rise_s)
    );

    state_e            state_q, state_d;
    logic [6:0]        shift_q, shift_d;   // MISO bits still to be presented
    logic [6:0]        rx_q, rx_d;         // MOSI bits received so far
    logic [2:0]        cnt_q, cnt_d;       // rising edges seen in current byte
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              dir_q, dir_d;       // 1 = write
    logic              miso_q, miso_d;
    logic              oe_q, oe_d;
    logic              irq_n_q, irq_n_d;
    logic              wr_pulse_q, wr_pulse_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    logic [DATA_W-1:0] rx_byte_s;
    logic              spi_we_s;
    logic [ADDR_W-1:0] spi_waddr_s;
    logic [DATA_W-1:0] spi_wdata_s;

    // Address to use for the next data byte of the transaction
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
`ifdef USB_SPI_RESP_AUTOINC_EN
        return a + ADDR_W'(1);
`else
        return a;
`endif
    endfunction

    // Byte as it stands once the current rising edge's MOSI bit is included
    assign rx_byte_s   = {rx_q, mosi_s};
    assign spi_waddr_s = addr_q;
    assign spi_wdata_s = rx_byte_s;

    // Transaction FSM: command decode, MOSI capture, MISO shifting
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        rx_d     = rx_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        dir_d    = dir_q;
        miso_d   = miso_q;
        spi_we_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_fall_s) begin
                    state_d = CMD;
                    cnt_d   = 3'd0;
                    miso_d  = regs_q[STATUS_REG][7];
                    shift_d = regs_q[STATUS_REG][6:0];
                end else begin
                    miso_d  = 1'b0;
                end
            end
            CMD: begin
                if (ss_rise_s) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                    miso_d  = 1'b0;
                end else if (!ss_n_s && sclk_rise_s) begin
                    rx_d  = rx_byte_s[6:0];
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        addr_d  = rx_byte_s[CMD_ADDR_MSB:CMD_ADDR_LSB];
                        dir_d   = rx_byte_s[CMD_DIR_BIT];
                        state_d = DATA;
                    end else begin
                        state_d = CMD;
                    end
                end else if (!ss_n_s && sclk_fall_s) begin
                    miso_d  = shift_q[6];
                    shift_d = {shift_q[5:0], 1'b0};
                end else begin
                    state_d = CMD;
                end
            end
            DATA: begin
                if (ss_rise_s) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                    miso_d  = 1'b0;
                end else if (!ss_n_s && sclk_rise_s) begin
                    rx_d  = rx_byte_s[6:0];
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        spi_we_s = dir_q;
                        addr_d   = next_addr(addr_q);
                    end else begin
                        spi_we_s = 1'b0;
                    end
                end else if (!ss_n_s && sclk_fall_s) begin
                    // cnt wrapped to 0: this fall closes a byte, start the next read byte
                    if (cnt_q == 3'd0 && !dir_q) begin
                        miso_d  = regs_q[addr_q][7];
                        shift_d = regs_q[addr_q][6:0];
                    end else begin
                        miso_d  = shift_q[6];
                        shift_d = {shift_q[5:0], 1'b0};
                    end
                end else begin
                    state_d = DATA;
                end
            end
            default: begin
                state_d = IDLE;
                miso_d  = 1'b0;
            end
        endcase
    end

    // Register bank update: SPI writes override host writes, except on the
    // status register where host sets and SPI clears combine
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NREGS; i++) begin
            if (i == STATUS_REG) begin
                if (host.host_we && host.host_addr == ADDR_W'(i)) begin
                    regs_d[i] = regs_d[i] | host.host_wdata;
                end else begin
                    regs_d[i] = regs_d[i];
                end
                if (spi_we_s && spi_waddr_s == ADDR_W'(i)) begin
                    regs_d[i] = regs_d[i] & ~spi_wdata_s;
                end else begin
                    regs_d[i] = regs_d[i];
                end
            end else begin
                if (host.host_we && host.host_addr == ADDR_W'(i)) begin
                    regs_d[i] = host.host_wdata;
                end else begin
                    regs_d[i] = regs_d[i];
                end
                if (spi_we_s && spi_waddr_s == ADDR_W'(i)) begin
                    regs_d[i] = spi_wdata_s;
                end else begin
                    regs_d[i] = regs_d[i];
                end
            end
        end
    end

    // Next values of the registered outputs
    always_comb begin
        oe_d       = (state_d != IDLE);
        irq_n_d    = ~irq_asserted(regs_q[STATUS_REG], regs_q[IEN_REG]);
        rdata_d    = regs_q[host.host_addr];
        wr_pulse_d = spi_we_s;
        if (spi_we_s) begin
            wr_addr_d = spi_waddr_s;
            wr_data_d = spi_wdata_s;
        end else begin
            wr_addr_d = wr_addr_q;
            wr_data_d = wr_data_q;
        end
    end

    // State, register bank and output flops
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            shift_q    <= 7'h00;
            rx_q       <= 7'h00;
            cnt_q      <= 3'd0;
            addr_q     <= 5'd0;
            dir_q      <= 1'b0;
            miso_q     <= 1'b0;
            oe_q       <= 1'b0;
            irq_n_q    <= 1'b1;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= 5'd0;
            wr_data_q  <= 8'h00;
            rdata_q    <= 8'h00;
            regs_q     <= '{default: 8'h00};
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            rx_q       <= rx_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            dir_q      <= dir_d;
            miso_q     <= miso_d;
            oe_q       <= oe_d;
            irq_n_q    <= irq_n_d;
            wr_pulse_q <= wr_pulse_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rdata_q    <= rdata_d;
            regs_q     <= regs_d;
        end
    end

    assign spi_miso        = miso_q;
    assign spi_miso_oe     = oe_q;
    assign irq_n           = irq_n_q;
    assign host.host_rdata = rdata_q;
    assign spi_wr_pulse    = wr_pulse_q;
    assign spi_wr_addr     = wr_addr_q;
    assign spi_wr_data     = wr_data_q;

endmodule
